// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//
// Shared types and constants for the iterative unsigned multiply/divide unit.
//   muldiv_op_t    : operation encoding as presented on the op port.
//   muldiv_state_t : control FSM state encoding.
//   XLEN_DEF       : default operand/result width.
//   DIV0_QUOT      : quotient returned by DIVU when the divisor is zero.
//   is_div()       : true for the two divide-class operations.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int          XLEN_DEF  = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MUL   = 2'd0,   // low half of the product
        OP_MULHU = 2'd1,   // high half of the product
        OP_DIVU  = 2'd2,   // quotient
        OP_REMU  = 2'd3    // remainder
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative unsigned multiply/divide unit sitting between the register-file
// read ports (RD1/RD2) and the writeback path to the write port (WD3/A3/WE3).
// One result bit-step per clock over a shared 2*XLEN shift register:
//   MUL/MULHU : shift-add, multiplicand added into the upper half.
//   DIVU/REMU : restoring division, divisor trial-subtracted from upper half.
// A divide with a zero divisor skips the datapath and completes in one cycle
// with the RISC-V defined result (all-ones quotient, remainder = dividend).
// ITER must equal XLEN: the datapath finishes after exactly XLEN steps.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-low reset
//   start   in   request; accepted only while busy=0 (IDLE or DONE)
//   op      in   [1:0] operation (see muldiv_op_t)
//   src_a   in   [XLEN-1:0] multiplicand / dividend (RD1)
//   src_b   in   [XLEN-1:0] multiplier / divisor   (RD2)
//   rd_in   in   [4:0] destination register index
//   busy    out  high while the datapath is iterating
//   done    out  one-cycle pulse; result/rd_out valid (drives WE3)
//   result  out  [XLEN-1:0] result (drives WD3), held until the next done
//   rd_out  out  [4:0] destination index (drives A3), held with result
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ITER = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    // ------------------------------------------------------------------------
    // State and operand registers
    // ------------------------------------------------------------------------
    muldiv_state_t     state_q;
    logic [CNT_W-1:0]  cnt_q;

    muldiv_op_t        op_in;
    muldiv_op_t        op_q;
    logic [4:0]        rd_q;
    // Multiplicand for multiplies, divisor for divides: whichever operand is
    // not loaded into the shift register.
    logic [XLEN-1:0]   opnd_q;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide  : {partial remainder, dividend bits / quotient bits}.
    logic [2*XLEN-1:0] acc_q;

    // ------------------------------------------------------------------------
    // Combinational control and datapath step
    // ------------------------------------------------------------------------
    logic              accept;
    logic              div_by_zero;
    logic              last_iter;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_rem_sh;
    logic [XLEN-1:0]   div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0]   run_result;
    logic [XLEN-1:0]   div0_result;

    assign op_in       = muldiv_op_t'(op);
    assign accept      = start && (state_q != S_RUN);
    assign div_by_zero = is_div(op_in) && (src_b == '0);
    assign last_iter   = (cnt_q == CNT_W'(ITER - 1));

    // NOTE: every signal written in an always_comb gets a value on every path
    // (defaults first); a path that leaves one unassigned infers a latch.
    always_comb begin
        mul_sum    = '0;
        mul_next   = acc_q;
        div_rem_sh = '0;
        div_diff   = '0;
        div_ok     = 1'b0;
        div_next   = acc_q;
        acc_step   = acc_q;

        // Shift-add: the add can carry out of the upper half, so the sum is
        // one bit wider and that carry is shifted back in from the top.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring division: the shifted partial remainder is XLEN+1 bits
        // wide (the bit leaving the top of the register still counts in the
        // comparison). When the subtraction succeeds the difference is below
        // the divisor, so its low XLEN bits are the whole difference.
        div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
        div_ok     = (div_rem_sh >= {1'b0, opnd_q});
        div_diff   = acc_q[2*XLEN-2:XLEN-1] - opnd_q;
        div_next   = div_ok ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                            : {acc_q[2*XLEN-2:0], 1'b0};

        acc_step = is_div(op_q) ? div_next : mul_next;
    end

    // MULHU and REMU take the upper half of the final register value; MUL and
    // DIVU take the lower half. Selected from the step value so the result can
    // be registered on the same edge that completes the last iteration.
    assign run_result  = ((op_q == OP_MULHU) || (op_q == OP_REMU))
                       ? acc_step[2*XLEN-1:XLEN]
                       : acc_step[XLEN-1:0];

    assign div0_result = (op_in == OP_DIVU) ? XLEN'(DIV0_QUOT) : src_a;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // NOTE: these registers carry no reset; they are always loaded on
    // acceptance before anything reads them, and the FSM gates their use.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op_in;
            rd_q  <= rd_in;
            if (is_div(op_in)) begin
                acc_q  <= {{XLEN{1'b0}}, src_a};
                opnd_q <= src_b;
            end else begin
                acc_q  <= {{XLEN{1'b0}}, src_b};
                opnd_q <= src_a;
            end
        end else if (state_q == S_RUN) begin
            acc_q <= acc_step;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    // NOTE: the reset is synchronous, so it is tested inside the clocked block
    // rather than appearing in the sensitivity list; all state updates here use
    // non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            done <= 1'b0;

            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cnt_q <= '0;
                        if (div_by_zero) begin
                            // Result is known without iterating.
                            state_q <= S_DONE;
                            done    <= 1'b1;
                            result  <= div0_result;
                            rd_out  <= rd_in;
                        end else begin
                            state_q <= S_RUN;
                            busy    <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_RUN: begin
                    // start is ignored here: no queueing while iterating.
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_q <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= run_result;
                        rd_out  <= rd_q;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Self-checking bench for muldiv_unit. A table of {op, operands, rd,
// expected result, expected latency} records is applied in a loop; hand-written
// sequences cover start-while-busy, back-to-back issue and reset mid-operation.
// Expected results are pushed onto a scoreboard when an operation is driven and
// popped by a monitor whenever done is seen.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        start  = 1'b0;
    logic [1:0]  op     = 2'd0;
    logic [31:0] src_a  = 32'd0;
    logic [31:0] src_b  = 32'd0;
    logic [4:0]  rd_in  = 5'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } sb_t;

    int    checks   = 0;
    int    failures = 0;
    sb_t   sb_q[$];
    string cur_name = "reset";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference model built from plain arithmetic, independent of the datapath.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic vec_t mk(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] r, input logic [31:0] e);
        vec_t v;
        v.op  = o;
        v.a   = a;
        v.b   = b;
        v.rd  = r;
        v.exp = e;
        v.lat = ((o == 2'd2 || o == 2'd3) && b == 32'd0) ? 1 : 33;
        return v;
    endfunction

    task automatic push_exp(input logic [31:0] res, input logic [4:0] r);
        sb_t e;
        e.res = res;
        e.rd  = r;
        sb_q.push_back(e);
    endtask

    task automatic scramble_inputs();
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
        rd_in = 5'($urandom);
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        sb_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check({cur_name, "_unexpected_done"}, 32'(done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({cur_name, "_result"}, result, e.res);
                check({cur_name, "_rd_out"}, 32'(rd_out), 32'(e.rd));
            end
        end
    end

    // Issue one operation, measure latency/busy cycles, then confirm the done
    // pulse is single-cycle and the result is held afterwards.
    task automatic run_op(input vec_t v, input string name);
        int lat;
        int busy_cnt;
        cur_name = name;
        @(negedge clk);
        start = 1'b1;
        op    = v.op;
        src_a = v.a;
        src_b = v.b;
        rd_in = v.rd;
        push_exp(v.exp, v.rd);
        @(posedge clk);
        lat      = 0;
        busy_cnt = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                scramble_inputs();
            end
            if (busy) busy_cnt++;
            if (done) break;
        end
        check({name, "_latency"}, 32'(lat), 32'(v.lat));
        check({name, "_busy_cycles"}, 32'(busy_cnt), (v.lat == 1) ? 32'd0 : 32'd32);
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_result_held"}, result, v.exp);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"},   32'(busy),   32'd0);
        check({name, "_done"},   32'(done),   32'd0);
        check({name, "_result"}, result,      32'd0);
        check({name, "_rd_out"}, 32'(rd_out), 32'd0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        vec_t vecs[$];
        int   lat;
        int   busy_cnt;
        int   done1_lat;
        int   done2_lat;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // ---------------- table-driven vectors ----------------
        vecs.push_back(mk(2'd0, 32'd7,          32'd6,          5'd5,  32'd42));
        vecs.push_back(mk(2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE));
        vecs.push_back(mk(2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0001));
        vecs.push_back(mk(2'd2, 32'd100,        32'd7,          5'd3,  32'd14));
        vecs.push_back(mk(2'd3, 32'd100,        32'd7,          5'd4,  32'd2));
        vecs.push_back(mk(2'd2, 32'h8000_0000,  32'd1,          5'd6,  32'h8000_0000));
        vecs.push_back(mk(2'd2, 32'd123,        32'd0,          5'd7,  32'hFFFF_FFFF));
        vecs.push_back(mk(2'd3, 32'd123,        32'd0,          5'd8,  32'd123));
        vecs.push_back(mk(2'd2, 32'hFFFF_FFFF,  32'h8000_0001,  5'd9,  32'd1));
        vecs.push_back(mk(2'd3, 32'hFFFF_FFFF,  32'h8000_0001,  5'd10, 32'h7FFF_FFFE));
        vecs.push_back(mk(2'd1, 32'h8000_0000,  32'd2,          5'd11, 32'd1));
        vecs.push_back(mk(2'd0, 32'h8000_0000,  32'd2,          5'd12, 32'd0));
        vecs.push_back(mk(2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd31, 32'd0));
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i >= 4) rb = rb >> 20;
            ro = 2'(i % 4);
            vecs.push_back(mk(ro, ra, rb, 5'(i + 13), model(ro, ra, rb)));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // ---------------- start while busy is ignored ----------------
        cur_name = "ignore_start";
        @(negedge clk);
        start = 1'b1; op = 2'd0; src_a = 32'd7; src_b = 32'd6; rd_in = 5'd5;
        push_exp(32'd42, 5'd5);
        @(posedge clk);
        lat = 0;
        busy_cnt = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin start = 1'b0; scramble_inputs(); end
            if (lat == 5) begin
                start = 1'b1; op = 2'd0; src_a = 32'd3; src_b = 32'd3; rd_in = 5'd9;
            end
            if (lat == 6) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) break;
        end
        check("ignore_start_latency", 32'(lat), 32'd33);
        check("ignore_start_busy_cycles", 32'(busy_cnt), 32'd32);
        repeat (40) @(negedge clk);   // a re-accepted start would raise a stray done

        // ---------------- back-to-back: start during DONE ----------------
        cur_name = "back_to_back";
        @(negedge clk);
        start = 1'b1; op = 2'd2; src_a = 32'd100; src_b = 32'd7; rd_in = 5'd3;
        push_exp(32'd14, 5'd3);
        @(posedge clk);
        lat = 0;
        done1_lat = 0;
        done2_lat = 0;
        while (lat < 150 && done2_lat == 0) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin start = 1'b0; scramble_inputs(); end
            if (done1_lat != 0 && lat == done1_lat + 1) begin
                check("back_to_back_busy_rise", 32'(busy), 32'd1);
                start = 1'b0;
                scramble_inputs();
            end
            if (done) begin
                if (done1_lat == 0) begin
                    done1_lat = lat;
                    start = 1'b1; op = 2'd3; src_a = 32'd1000; src_b = 32'd9; rd_in = 5'd4;
                    push_exp(32'd1, 5'd4);
                end else begin
                    done2_lat = lat;
                end
            end
        end
        check("back_to_back_first_done", 32'(done1_lat), 32'd33);
        check("back_to_back_second_done", 32'(done2_lat), 32'd66);

        // ---------------- reset mid-RUN aborts ----------------
        cur_name = "reset_abort";
        @(negedge clk);
        start = 1'b1; op = 2'd0; src_a = 32'h0000_FFFF; src_b = 32'h0000_FFFF; rd_in = 5'd7;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin start = 1'b0; scramble_inputs(); end
        end
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_abort");
        rst = 1'b1;
        repeat (40) @(negedge clk);   // an aborted op must never produce done
        run_op(mk(2'd0, 32'h0000_FFFF, 32'h0000_FFFF, 5'd7, 32'hFFFE_0001), "after_reset");

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide unit downstream of the register file: takes the two operands read on RD1/RD2, computes over multiple cycles, and returns the result with its destination register index. The outputs drive the register-file write port (WD3/A3/WE3) through writeback. It adds MUL/MULHU/DIVU/REMU to the processor without a combinational 32×32 multiplier or divider.

## Interface
- XLEN, 32: operand/result width.
- ITER, 32: iterations per operation; must equal XLEN.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request; accepted only when busy=0.
- op  input  2  operation: 0 MUL (low product), 1 MULHU (high product), 2 DIVU (quotient), 3 REMU (remainder).
- src_a  input  XLEN  multiplicand/dividend (from RD1).
- src_b  input  XLEN  multiplier/divisor (from RD2).
- rd_in  input  5  destination register index.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse; result and rd_out valid; drives WE3.
- result  output  XLEN  drives WD3; held until the next done.
- rd_out  output  5  drives A3; held with result.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1: latch op, src_a, src_b, rd_in; clear the iteration counter; go to RUN. Exception: divide op with src_b=0 goes to DONE.
- RUN, multiply: shift-add over a 2×XLEN accumulator. Each cycle, if multiplier bit0=1 add the multiplicand into the upper half, then shift right one bit including carry.
- RUN, divide: restoring division over a 2×XLEN remainder/quotient register. Each cycle, shift left one bit and trial-subtract the divisor from the upper half. If no borrow, keep the difference and set quotient bit0=1.
- RUN counter: counts 0..ITER-1. At ITER-1, go to DONE.
- DONE: done=1 for exactly one cycle; load result/rd_out. Next state is IDLE unless start=1, which is accepted as above.
- Result selection:
  - MUL: product[31:0].
  - MULHU: product[63:32].
  - DIVU: quotient.
  - REMU: remainder.
- Divide by zero (RISC-V semantics): DIVU returns 0xFFFFFFFF; REMU returns src_a.
- start while busy=1 is ignored; no queueing and no error flag.
- op, src_a, src_b and rd_in are sampled only at acceptance. Later changes have no effect.
- All arithmetic is unsigned. The product is exactly 64 bits, so no overflow is possible.

## Timing
- Reset values: busy=0, done=0, result=0, rd_out=0, state IDLE, counter 0.
- Reset mid-RUN aborts the operation; no done is produced for it.
- Normal operation, start accepted at edge k:
  - busy=1 from k+1 through k+ITER.
  - done=1 in cycle k+ITER+1.
  - Total latency is ITER+1 cycles.
- Divide by zero, start accepted at edge k: done=1 in cycle k+1; busy stays 0.
- Back-to-back: start during the DONE cycle is accepted, and busy rises the next cycle. Maximum throughput is one operation per ITER+1 cycles.
- result/rd_out change only on the edge that raises done.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package muldiv_pkg contains:
  - muldiv_op_t enum {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU} (2 bits).
  - muldiv_state_t enum {S_IDLE, S_RUN, S_DONE}.
  - Constants XLEN_DEF=32 and DIV0_QUOT=32'hFFFFFFFF.
- Single module with no sub-module. Control FSM and the shared 2×XLEN shift datapath share the counter and operand registers.

## Test plan
- MUL 7×6, rd_in=5: done in cycle k+33, result=42, rd_out=5; busy high exactly 32 cycles.
- MULHU 0xFFFFFFFF×0xFFFFFFFF: result=0xFFFFFFFE. MUL of the same operands: result=0x00000001.
- DIVU 100/7: result=14. REMU 100/7: result=2. DIVU 0x80000000/1: result=0x80000000.
- DIVU 123/0: result=0xFFFFFFFF at k+1. REMU 123/0: result=123; busy never asserted.
- Start pulsed with new operands at k+5 during RUN: ignored; the first result is unchanged. Start during DONE: second op accepted and completes at k+66.
- rst=0 at k+10 mid-RUN: next cycle all outputs are at reset values; no done pulse. A new start after reset release completes normally.
